// File: rtl/dram_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dram_req_arbiter_if
//  Description : Bundle of the client-side and controller-FIFO-side signals
//                of the two-client DRAM request arbiter.
//                  slave  - arbiter view (drives acks, responses, FIFO strobes)
//                  master - environment view (clients + controller FIFOs)
//                Signals:
//                  cl_valid/cl_wr/cl_addr*/cl_wdata*  client requests
//                  cl_ack                             request accepted pulse
//                  rsp_valid/rsp_data/rsp_ready       read response handshake
//                  frq_*                              request FIFO push side
//                  fin_*                              input (write data) FIFO
//                  fout_*                             output (read data) FIFO
//                  error                              sticky protocol error
//  Revision    : 1.0 - initial release
// ============================================================================
interface dram_req_arbiter_if #(
    parameter int PAGE_LEN      = 32,
    parameter int LOG_ADDR_SIZE = 1,
    parameter int LOG_REQ_SIZE  = 1 + LOG_ADDR_SIZE
);
    logic [1:0]               cl_valid;
    logic [1:0]               cl_wr;
    logic [LOG_ADDR_SIZE-1:0] cl_addr0;
    logic [LOG_ADDR_SIZE-1:0] cl_addr1;
    logic [PAGE_LEN-1:0]      cl_wdata0;
    logic [PAGE_LEN-1:0]      cl_wdata1;
    logic [1:0]               cl_ack;

    logic [1:0]               rsp_valid;
    logic [PAGE_LEN-1:0]      rsp_data;
    logic [1:0]               rsp_ready;

    logic                     frq_write_en;
    logic [LOG_REQ_SIZE-1:0]  frq_write_data;
    logic                     frq_full;

    logic                     fin_write_en;
    logic [PAGE_LEN-1:0]      fin_write_data;
    logic                     fin_full;

    logic                     fout_read_en;
    logic [PAGE_LEN-1:0]      fout_read_data;
    logic                     fout_empty;

    logic                     error;

    modport slave (
        input  cl_valid, cl_wr, cl_addr0, cl_addr1, cl_wdata0, cl_wdata1,
        output cl_ack,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        output frq_write_en, frq_write_data,
        input  frq_full,
        output fin_write_en, fin_write_data,
        input  fin_full,
        output fout_read_en,
        input  fout_read_data, fout_empty,
        output error
    );

    modport master (
        output cl_valid, cl_wr, cl_addr0, cl_addr1, cl_wdata0, cl_wdata1,
        input  cl_ack,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        input  frq_write_en, frq_write_data,
        output frq_full,
        input  fin_write_en, fin_write_data,
        output fin_full,
        input  fout_read_en,
        output fout_read_data, fout_empty,
        input  error
    );
endinterface : dram_req_arbiter_if
`default_nettype wire

// File: rtl/dram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dram_req_arbiter
//  Description : Shares a single-page DRAM controller between two clients.
//                Granted requests are pushed into the controller request
//                FIFO ({addr, wr}, bit0 = wr) and write pages into its input
//                FIFO. Read pages from the output FIFO are routed back to the
//                issuing client through an in-order tag FIFO and a one-entry
//                response register.
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset
//                bus  - dram_req_arbiter_if.slave (clients + controller FIFOs)
//  Build macro : ARB_FIXED_PRIO_EN - strict priority (client 0 wins) instead
//                of round-robin; no arbitration pointer is built.
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_req_arbiter #(
    parameter int PAGE_LEN      = 32,
    parameter int LOG_ADDR_SIZE = 1,
    parameter int LOG_REQ_SIZE  = 1 + LOG_ADDR_SIZE,
    parameter int TAG_DEPTH     = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dram_req_arbiter_if.slave  bus
);

    localparam int c_TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [c_TAG_AW-1:0] c_PTR_ONE  = c_TAG_AW'(1);
    localparam logic [c_TAG_AW:0]   c_CNT_ONE  = (c_TAG_AW+1)'(1);
    localparam logic [c_TAG_AW:0]   c_CNT_FULL = (c_TAG_AW+1)'(TAG_DEPTH);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                   r_state;
    logic                     r_frq_we;
    logic [LOG_REQ_SIZE-1:0]  r_frq_wd;
    logic                     r_fin_we;
    logic [PAGE_LEN-1:0]      r_fin_wd;
    logic [1:0]               r_ack;
    logic                     r_gnt;       // client granted in the current ISSUE

    logic [TAG_DEPTH-1:0]     r_tag_mem;   // one bit per entry: issuing client
    logic [c_TAG_AW-1:0]      r_tag_wp;
    logic [c_TAG_AW-1:0]      r_tag_rp;
    logic [c_TAG_AW:0]        r_tag_cnt;

    logic [1:0]               r_rsp_valid;
    logic [PAGE_LEN-1:0]      r_rsp_data;
    logic                     r_error;

    // ------------------------------------------------------------------
    // Eligibility and grant selection
    // ------------------------------------------------------------------
    logic                     w_tag_full;
    logic                     w_tag_empty;
    logic [1:0]               w_elig;
    logic                     w_any_elig;
    logic                     w_gnt;
    logic                     w_sel_wr;
    logic [LOG_ADDR_SIZE-1:0] w_sel_addr;
    logic [PAGE_LEN-1:0]      w_sel_wdata;

    assign w_tag_full  = (r_tag_cnt == c_CNT_FULL);
    assign w_tag_empty = (r_tag_cnt == '0);

    // A write needs room in the input FIFO, a read needs a free tag slot.
    assign w_elig[0] = bus.cl_valid[0] & ~bus.frq_full &
                       (bus.cl_wr[0] ? ~bus.fin_full : ~w_tag_full);
    assign w_elig[1] = bus.cl_valid[1] & ~bus.frq_full &
                       (bus.cl_wr[1] ? ~bus.fin_full : ~w_tag_full);
    assign w_any_elig = |w_elig;

`ifdef ARB_FIXED_PRIO_EN
    assign w_gnt = ~w_elig[0];
`else
    logic r_ptr;   // client that gets first look in the next arbitration

    // Start from the pointer; fall over to the other client when the
    // pointed-to client is not eligible.
    assign w_gnt = r_ptr ? w_elig[1] : ~w_elig[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (r_state == ST_ISSUE) begin
            r_ptr <= ~r_gnt;
        end
    end
`endif

    assign w_sel_wr    = w_gnt ? bus.cl_wr[1]  : bus.cl_wr[0];
    assign w_sel_addr  = w_gnt ? bus.cl_addr1  : bus.cl_addr0;
    assign w_sel_wdata = w_gnt ? bus.cl_wdata1 : bus.cl_wdata0;

    // ------------------------------------------------------------------
    // Request FSM. The strobes are only ever high in ISSUE, and ISSUE always
    // returns to ARB, so the FIFO full flags are re-sampled after each push.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_ARB;
            r_frq_we <= 1'b0;
            r_frq_wd <= '0;
            r_fin_we <= 1'b0;
            r_fin_wd <= '0;
            r_ack    <= 2'b00;
            r_gnt    <= 1'b0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_any_elig) begin
                        r_frq_we <= 1'b1;
                        r_frq_wd <= {w_sel_addr, w_sel_wr};
                        r_fin_we <= w_sel_wr;
                        r_fin_wd <= w_sel_wdata;
                        r_ack    <= w_gnt ? 2'b10 : 2'b01;
                        r_gnt    <= w_gnt;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_frq_we <= 1'b0;
                    r_fin_we <= 1'b0;
                    r_ack    <= 2'b00;
                    r_state  <= ST_ARB;
                end
                default: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO and response register
    // ------------------------------------------------------------------
    logic w_push;
    logic w_drain;
    logic w_load;
    logic w_tag_head;

    assign w_push     = (r_state == ST_ISSUE) & ~r_frq_wd[0];
    assign w_drain    = |(r_rsp_valid & bus.rsp_ready);
    assign w_load     = (~|r_rsp_valid | w_drain) & ~bus.fout_empty & ~w_tag_empty;
    assign w_tag_head = r_tag_mem[r_tag_rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_mem <= '0;
            r_tag_wp  <= '0;
            r_tag_rp  <= '0;
            r_tag_cnt <= '0;
        end else begin
            if (w_push) begin
                r_tag_mem[r_tag_wp] <= r_gnt;
                r_tag_wp            <= r_tag_wp + c_PTR_ONE;
            end
            if (w_load) begin
                r_tag_rp <= r_tag_rp + c_PTR_ONE;
            end
            case ({w_push, w_load})
                2'b10:   r_tag_cnt <= r_tag_cnt + c_CNT_ONE;
                2'b01:   r_tag_cnt <= r_tag_cnt - c_CNT_ONE;
                default: r_tag_cnt <= r_tag_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= '0;
        end else if (w_load) begin
            r_rsp_valid <= w_tag_head ? 2'b10 : 2'b01;
            r_rsp_data  <= bus.fout_read_data;
        end else if (w_drain) begin
            r_rsp_valid <= 2'b00;
        end
    end

    // ------------------------------------------------------------------
    // Sticky protocol error
    // ------------------------------------------------------------------
    logic w_err_orphan;
    logic w_err_ready;

    assign w_err_orphan = ~bus.fout_empty & w_tag_empty & ~w_push;
    assign w_err_ready  = |(bus.rsp_ready & ~r_rsp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (w_err_orphan | w_err_ready) begin
            r_error <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The output FIFO pop is asserted in the same cycle its head is
    // captured: with a first-word-fall-through FIFO this is what allows a
    // fresh response every cycle without reading one word twice.
    // ------------------------------------------------------------------
    assign bus.cl_ack         = r_ack;
    assign bus.frq_write_en   = r_frq_we;
    assign bus.frq_write_data = r_frq_wd;
    assign bus.fin_write_en   = r_fin_we;
    assign bus.fin_write_data = r_fin_wd;
    assign bus.fout_read_en   = w_load;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_data       = r_rsp_data;
    assign bus.error          = r_error;

endmodule : dram_req_arbiter
`default_nettype wire

// File: tb/tb_dram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_req_arbiter
//  Description : Directed self-checking bench for dram_req_arbiter. Models
//                the controller output FIFO as a small first-word-fall-through
//                buffer; clients answer responses whenever they are valid.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dram_req_arbiter;

    localparam int PAGE_LEN      = 32;
    localparam int LOG_ADDR_SIZE = 1;
    localparam int LOG_REQ_SIZE  = 2;
    localparam int TAG_DEPTH     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_req_arbiter_if #(
        .PAGE_LEN      (PAGE_LEN),
        .LOG_ADDR_SIZE (LOG_ADDR_SIZE),
        .LOG_REQ_SIZE  (LOG_REQ_SIZE)
    ) bus ();

    dram_req_arbiter #(
        .PAGE_LEN      (PAGE_LEN),
        .LOG_ADDR_SIZE (LOG_ADDR_SIZE),
        .LOG_REQ_SIZE  (LOG_REQ_SIZE),
        .TAG_DEPTH     (TAG_DEPTH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Output FIFO model: pushed by the stimulus, popped on fout_read_en.
    logic [PAGE_LEN-1:0] fmem [0:7];
    int                  fwp = 0;
    int                  frp = 0;
    logic [2:0]          frp_idx;

    assign frp_idx             = frp[2:0];
    assign bus.fout_empty      = (fwp == frp);
    assign bus.fout_read_data  = fmem[frp_idx];

    always @(posedge clk) begin
        if (bus.fout_read_en && (fwp != frp)) frp <= frp + 1;
    end

    // Clients accept a response as soon as it is presented.
    logic ready_en = 1'b1;
    assign bus.rsp_ready = ready_en ? bus.rsp_valid : 2'b00;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic fout_push(input logic [PAGE_LEN-1:0] d);
        fmem[fwp % 8] = d;
        fwp = fwp + 1;
    endtask

    // Wait (bounded) for an ack, check which client got it, then drop that
    // client's request. Always advances at least one cycle.
    task automatic wait_ack(input logic [1:0] exp, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.cl_ack == 2'b00 && n < 20);
        chk_eq(tag, bus.cl_ack, exp);
        bus.cl_valid = bus.cl_valid & ~bus.cl_ack;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acked;
        bus.cl_valid  = 2'b00;
        bus.cl_wr     = 2'b00;
        bus.cl_addr0  = '0;
        bus.cl_addr1  = '0;
        bus.cl_wdata0 = '0;
        bus.cl_wdata1 = '0;
        bus.frq_full  = 1'b0;
        bus.fin_full  = 1'b0;

        // ---------------- reset / idle ----------------
        repeat (2) @(negedge clk);
        chk_eq("rst_ack",      bus.cl_ack,         2'b00);
        chk_eq("rst_frq_we",   bus.frq_write_en,   1'b0);
        chk_eq("rst_frq_wd",   bus.frq_write_data, 2'b00);
        chk_eq("rst_fin_we",   bus.fin_write_en,   1'b0);
        chk_eq("rst_fin_wd",   bus.fin_write_data, 32'h0);
        chk_eq("rst_rsp_v",    bus.rsp_valid,      2'b00);
        chk_eq("rst_rsp_d",    bus.rsp_data,       32'h0);
        chk_eq("rst_fout_re",  bus.fout_read_en,   1'b0);
        chk_eq("rst_error",    bus.error,          1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("idle_frq_we",  bus.frq_write_en,   1'b0);
        chk_eq("idle_error",   bus.error,          1'b0);

        // ---------------- two reads, round-robin ----------------
        bus.cl_valid = 2'b11;
        bus.cl_wr    = 2'b00;
        bus.cl_addr0 = 1'b0;
        bus.cl_addr1 = 1'b1;
        @(negedge clk);
        chk_eq("rd0_ack",      bus.cl_ack,         2'b01);
        chk_eq("rd0_frq_we",   bus.frq_write_en,   1'b1);
        chk_eq("rd0_frq_wd",   bus.frq_write_data, 2'b00);
        chk_eq("rd0_fin_we",   bus.fin_write_en,   1'b0);
        bus.cl_valid = 2'b10;
        @(negedge clk);
        chk_eq("gap_frq_we",   bus.frq_write_en,   1'b0);
        chk_eq("gap_ack",      bus.cl_ack,         2'b00);
        @(negedge clk);
        chk_eq("rd1_ack",      bus.cl_ack,         2'b10);
        chk_eq("rd1_frq_we",   bus.frq_write_en,   1'b1);
        chk_eq("rd1_frq_wd",   bus.frq_write_data, 2'b10);
        bus.cl_valid = 2'b00;
        @(negedge clk);

        // ---------------- responses back-to-back ----------------
        fout_push(32'hA);
        fout_push(32'hB);
        #1;
        chk_eq("rspA_fout_re", bus.fout_read_en,   1'b1);
        @(negedge clk);
        chk_eq("rspA_valid",   bus.rsp_valid,      2'b01);
        chk_eq("rspA_data",    bus.rsp_data,       32'hA);
        @(negedge clk);
        chk_eq("rspB_valid",   bus.rsp_valid,      2'b10);
        chk_eq("rspB_data",    bus.rsp_data,       32'hB);
        @(negedge clk);
        chk_eq("rsp_idle",     bus.rsp_valid,      2'b00);
        chk_eq("rsp_error",    bus.error,          1'b0);

        // ---------------- ineligible write does not block a read ----------------
        bus.cl_valid  = 2'b11;
        bus.cl_wr     = 2'b01;
        bus.cl_addr0  = 1'b1;
        bus.cl_wdata0 = 32'hDEADBEEF;
        bus.cl_addr1  = 1'b0;
        bus.fin_full  = 1'b1;
        @(negedge clk);
        chk_eq("blk_ack",      bus.cl_ack,         2'b10);
        chk_eq("blk_frq_wd",   bus.frq_write_data, 2'b00);
        chk_eq("blk_fin_we",   bus.fin_write_en,   1'b0);
        bus.cl_valid = 2'b01;
        @(negedge clk);
        bus.fin_full = 1'b0;
        @(negedge clk);
        chk_eq("wr_ack",       bus.cl_ack,         2'b01);
        chk_eq("wr_frq_wd",    bus.frq_write_data, 2'b11);
        chk_eq("wr_fin_we",    bus.fin_write_en,   1'b1);
        chk_eq("wr_fin_wd",    bus.fin_write_data, 32'hDEADBEEF);
        bus.cl_valid = 2'b00;
        @(negedge clk);
        fout_push(32'h12345678);
        @(negedge clk);
        chk_eq("rspC_valid",   bus.rsp_valid,      2'b10);
        chk_eq("rspC_data",    bus.rsp_data,       32'h12345678);
        @(negedge clk);
        chk_eq("rspC_idle",    bus.rsp_valid,      2'b00);

        // ---------------- tag FIFO full ----------------
        bus.cl_wr    = 2'b00;
        bus.cl_addr0 = 1'b0;
        for (int i = 0; i < TAG_DEPTH; i++) begin
            bus.cl_valid = 2'b01;
            wait_ack(2'b01, $sformatf("fill%0d_ack", i));
        end
        bus.cl_valid = 2'b01;
        acked = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.cl_ack != 2'b00) acked = 1'b1;
        end
        chk_eq("full_no_ack",  acked,              1'b0);
        fout_push(32'h11);
        @(negedge clk);
        chk_eq("full_rsp_v",   bus.rsp_valid,      2'b01);
        chk_eq("full_rsp_d",   bus.rsp_data,       32'h11);
        wait_ack(2'b01, "full_late_ack");
        for (int i = 0; i < TAG_DEPTH; i++) fout_push(32'h20 + i);
        repeat (10) @(negedge clk);
        chk_eq("full_drained", bus.fout_empty,     1'b1);
        chk_eq("full_rsp_idle",bus.rsp_valid,      2'b00);
        chk_eq("full_error",   bus.error,          1'b0);

        // ---------------- orphan data -> sticky error ----------------
        fout_push(32'h99);
        @(negedge clk);
        chk_eq("err_set",      bus.error,          1'b1);
        fwp = frp;
        repeat (2) @(negedge clk);
        chk_eq("err_held",     bus.error,          1'b1);

        // ---------------- async reset mid-ISSUE ----------------
        bus.cl_valid = 2'b10;
        bus.cl_wr    = 2'b00;
        wait_ack(2'b10, "pre_rst_ack");
        chk_eq("pre_rst_frq",  bus.frq_write_en,   1'b1);
        rst = 1'b1;
        #1;
        chk_eq("arst_ack",     bus.cl_ack,         2'b00);
        chk_eq("arst_frq_we",  bus.frq_write_en,   1'b0);
        chk_eq("arst_frq_wd",  bus.frq_write_data, 2'b00);
        chk_eq("arst_error",   bus.error,          1'b0);
        chk_eq("arst_rsp_v",   bus.rsp_valid,      2'b00);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("post_frq_we",  bus.frq_write_en,   1'b0);
        chk_eq("post_error",   bus.error,          1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_dram_req_arbiter
`default_nettype wire
